// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer.
// The state enum and the counter-width helper live here so a bench or wrapper can import them.
package word_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Word-index counter width; a single-word block still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial word serializer: one DEPTH-word block in, one word per cycle out.
// Build macro WORD_SERIALIZER_MSB_FIRST_EN emits word DEPTH-1 first instead of word 0.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iClr,
  input  logic                      iLoadValid,
  output logic                      oLoadReady,
  input  logic [BITWIDTH*DEPTH-1:0] iLoadData,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [BITWIDTH-1:0]       oData,
  output logic                      oLast,
  output logic                      oBusy
);

  localparam int            CW       = clog2_min1(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  ser_state_t          r_state;
  logic [CW-1:0]       r_cnt;
  logic [BITWIDTH-1:0] r_mem [DEPTH];

  logic          w_shift;
  logic          w_at_last;
  logic          w_load;
  logic [CW-1:0] w_idx;

  // Handshakes: a load happens on iLoadValid && oLoadReady at a rising edge;
  // a word transfers on oValid && iReady. Nothing moves on either side otherwise.
  assign w_shift    = (r_state == SHIFT);
  assign w_at_last  = (r_cnt == LAST_CNT);
  assign oLoadReady = !w_shift || (w_at_last && iReady);
  assign w_load     = iLoadValid && oLoadReady;

`ifdef WORD_SERIALIZER_MSB_FIRST_EN
  assign w_idx = LAST_CNT - r_cnt;
`else
  assign w_idx = r_cnt;
`endif

  // Outputs come straight from state, counter and storage; iReady never reaches oData.
  assign oValid = w_shift;
  assign oBusy  = w_shift;
  assign oLast  = w_shift && w_at_last;
  assign oData  = w_shift ? r_mem[w_idx] : '0;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (iClr) begin
      // Clear wins over any load or transfer in the same cycle.
      r_state <= IDLE;
      r_cnt   <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            for (int k = 0; k < DEPTH; k++)
              r_mem[k] <= iLoadData[k*BITWIDTH +: BITWIDTH];
          end
        end
        SHIFT: begin
          if (iReady) begin
            if (!w_at_last) begin
              r_cnt <= r_cnt + CW'(1);
            end else if (w_load) begin
              // Last word leaves while the next block lands: no bubble.
              r_cnt <= '0;
              for (int k = 0; k < DEPTH; k++)
                r_mem[k] <= iLoadData[k*BITWIDTH +: BITWIDTH];
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
